polymult_arbiter: RTL and testbench

POLYMULT_ARBITER -- requirements
Module: polymult_arbiter

---
 rtl/polymult_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_polymult_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polymult_arbiter.sv
// Round-robin arbiter granting one of NREQ requesters exclusive use of the
// shared polynomial multiplier, with degree checking and a WAIT timeout.
module polymult_arbiter #(
  parameter int          NREQ    = 3,
  parameter logic [19:0] TIMEOUT = 20'd786432,
  parameter logic [10:0] DEGMAX  = 11'd756
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [11*NREQ-1:0] req_dega_i,
  input  logic [11*NREQ-1:0] req_degb_i,
  input  logic              mult_done_i,
  output logic              mult_start_o,
  output logic [10:0]       mult_dega_o,
  output logic [10:0]       mult_degb_o,
  output logic [1:0]        sel_o,
  output logic [NREQ-1:0]   grant_o,
  output logic [NREQ-1:0]   done_o,
  output logic [NREQ-1:0]   err_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic [1:0]        gIdx_q, gIdx_d;
  logic [1:0]        rrPtr_q, rrPtr_d;
  logic [19:0]       cnt_q, cnt_d;
  logic              start_q, start_d;
  logic [10:0]       dega_q, dega_d;
  logic [10:0]       degb_q, degb_d;
  logic [1:0]        sel_q, sel_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic              busy_q, busy_d;

  logic              pickValid;
  logic [1:0]        pickIdx;
  logic [1:0]        cand;
  logic [10:0]       pickDega;
  logic [10:0]       pickDegb;
  logic [19:0]       cntInc;

  // Scan downward so the requester closest at/after rrPtr_q is the last writer.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = 2'd0;
    cand      = 2'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = 2'((int'(rrPtr_q) + i) % NREQ);
      if (req_i[cand]) begin
        pickValid = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  always_comb begin
    pickDega = 11'd0;
    pickDegb = 11'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (pickIdx == 2'(i)) begin
        pickDega = req_dega_i[i*11 +: 11];
        pickDegb = req_degb_i[i*11 +: 11];
      end
    end
  end

  assign cntInc = (cnt_q == 20'hFFFFF) ? cnt_q : cnt_q + 20'd1;

  always_comb begin
    state_d = state_q;
    gIdx_d  = gIdx_q;
    rrPtr_d = rrPtr_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    dega_d  = dega_q;
    degb_d  = degb_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = '0;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        sel_d   = 2'd0;
        dega_d  = 11'd0;
        degb_d  = 11'd0;
        if (pickValid) begin
          state_d          = LOAD;
          gIdx_d           = pickIdx;
          sel_d            = pickIdx;
          grant_d[pickIdx] = 1'b1;
          dega_d           = pickDega;
          degb_d           = pickDegb;
        end
      end
      LOAD: begin
        if (dega_q > DEGMAX || degb_q > DEGMAX) begin
          state_d = ERR;
          err_d   = grant_q;
        end else begin
          state_d = START;
          start_d = 1'b1;
          cnt_d   = 20'd0;
        end
      end
      START: begin
        state_d = WAIT;
        cnt_d   = cntInc;
      end
      // Completion takes priority over a timeout landing in the same cycle.
      WAIT: begin
        if (mult_done_i) begin
          state_d = DONE;
          done_d  = grant_q;
        end else if (cnt_q == TIMEOUT - 20'd1) begin
          state_d = ERR;
          err_d   = grant_q;
        end else begin
          cnt_d = cntInc;
        end
      end
      DONE, ERR: begin
        state_d = IDLE;
        rrPtr_d = (gIdx_q == 2'(NREQ - 1)) ? 2'd0 : gIdx_q + 2'd1;
        grant_d = '0;
        sel_d   = 2'd0;
        dega_d  = 11'd0;
        degb_d  = 11'd0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gIdx_q  <= 2'd0;
      rrPtr_q <= 2'd0;
      cnt_q   <= 20'd0;
      start_q <= 1'b0;
      dega_q  <= 11'd0;
      degb_q  <= 11'd0;
      sel_q   <= 2'd0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gIdx_q  <= gIdx_d;
      rrPtr_q <= rrPtr_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      dega_q  <= dega_d;
      degb_q  <= degb_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign mult_start_o = start_q;
  assign mult_dega_o  = dega_q;
  assign mult_degb_o  = degb_q;
  assign sel_o        = sel_q;
  assign grant_o      = grant_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_polymult_arbiter.sv
// Scoreboard-driven bench for polymult_arbiter; a second instance with a
// short TIMEOUT exercises the WAIT abort path.
module tb_polymult_arbiter;

  localparam int NREQ = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  reqT = '0;
  logic [32:0] dega = '0;
  logic [32:0] degb = '0;
  logic        multDone = 1'b0;

  logic        start, startT;
  logic [10:0] mDega, mDegb, mDegaT, mDegbT;
  logic [1:0]  sel, selT;
  logic [2:0]  grant, grantT, done, doneT, err, errT;
  logic        busy, busyT;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0] grant;
    logic       isErr;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  polymult_arbiter #(.NREQ(NREQ), .TIMEOUT(20'd64), .DEGMAX(11'd756)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_dega_i(dega), .req_degb_i(degb),
    .mult_done_i(multDone), .mult_start_o(start), .mult_dega_o(mDega),
    .mult_degb_o(mDegb), .sel_o(sel), .grant_o(grant), .done_o(done),
    .err_o(err), .busy_o(busy)
  );

  polymult_arbiter #(.NREQ(NREQ), .TIMEOUT(20'd16), .DEGMAX(11'd756)) dutT (
    .clk_i(clk), .rst_i(rst), .req_i(reqT), .req_dega_i(dega), .req_degb_i(degb),
    .mult_done_i(multDone), .mult_start_o(startT), .mult_dega_o(mDegaT),
    .mult_degb_o(mDegbT), .sel_o(selT), .grant_o(grantT), .done_o(doneT),
    .err_o(errT), .busy_o(busyT)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    req = '0;
    reqT = '0;
    multDone = 1'b0;
    dega = {11'd100, 11'd100, 11'd100};
    degb = {11'd200, 11'd200, 11'd200};
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vectors++;
    if ({start, mDega, mDegb, sel, grant, done, err, busy} !== 34'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {start, mDega, mDegb, sel, grant, done, err, busy});
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || grant !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: busy=%b grant=%b expected 0/000", busy, grant);
    end
  endtask

  task automatic test_single();
    bit held;
    doReset();
    dega[10:0] = 11'd756;
    degb[10:0] = 11'd756;
    req = 3'b001;
    sb.push_back('{grant: 3'b001, isErr: 1'b0});
    tick();
    vectors++;
    if (grant !== 3'b001 || sel !== 2'd0 || mDega !== 11'd756 || mDegb !== 11'd756 || start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_load: grant=%b sel=%0d dega=%0d degb=%0d start=%b expected 001/0/756/756/0",
               grant, sel, mDega, mDegb, start);
    end
    tick();
    vectors++;
    if (start !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_start_latency: start=%b expected 1", start);
    end
    tick();
    vectors++;
    if (start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_start_pulse: start=%b expected 0", start);
    end
    held = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (grant !== 3'b001 || busy !== 1'b1 || done !== 3'b000) held = 1'b0;
      tick();
    end
    vectors++;
    if (held !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_grant_held: held=%b expected 1", held);
    end
    multDone = 1'b1;
    tick();
    multDone = 1'b0;
    req = '0;
    e = sb.pop_front();
    vectors++;
    if (done !== e.grant || err !== 3'b000 || grant !== e.grant) begin
      miscompares++;
      $display("[TB] FAIL single_done: done=%b err=%b grant=%b expected %b/000/%b",
               done, err, grant, e.grant, e.grant);
    end
    tick();
    vectors++;
    if (done !== 3'b000 || busy !== 1'b0 || grant !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL single_idle_after: done=%b busy=%b grant=%b expected 000/0/000", done, busy, grant);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    req = 3'b111;
    multDone = 1'b1;
    sb.push_back('{grant: 3'b001, isErr: 1'b0});
    sb.push_back('{grant: 3'b010, isErr: 1'b0});
    sb.push_back('{grant: 3'b100, isErr: 1'b0});
    sb.push_back('{grant: 3'b001, isErr: 1'b0});
    for (int k = 0; k < 4; k++) begin
      e = sb.pop_front();
      tick();
      vectors++;
      if (grant !== e.grant) begin
        miscompares++;
        $display("[TB] FAIL rr_grant_%0d: grant=%b expected %b", k, grant, e.grant);
      end
      tick();
      tick();
      tick();
      vectors++;
      if (done !== e.grant || grant !== e.grant) begin
        miscompares++;
        $display("[TB] FAIL rr_done_%0d: done=%b grant=%b expected %b", k, done, grant, e.grant);
      end
      if (k == 3) begin
        req = '0;
        multDone = 1'b0;
      end
      tick();
      vectors++;
      if (done !== 3'b000 || grant !== 3'b000 || busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rr_idle_%0d: done=%b grant=%b busy=%b expected 000/000/0", k, done, grant, busy);
      end
    end
  endtask

  task automatic test_illegal_degree();
    doReset();
    dega[21:11] = 11'd757;
    req = 3'b010;
    sb.push_back('{grant: 3'b010, isErr: 1'b1});
    tick();
    vectors++;
    if (grant !== 3'b010 || sel !== 2'd1 || start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL illegal_load: grant=%b sel=%0d start=%b expected 010/1/0", grant, sel, start);
    end
    tick();
    e = sb.pop_front();
    vectors++;
    if (err !== e.grant || done !== 3'b000 || start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL illegal_err: err=%b done=%b start=%b expected %b/000/0", err, done, start, e.grant);
    end
    req = '0;
    tick();
    vectors++;
    if (err !== 3'b000 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL illegal_idle: err=%b busy=%b expected 000/0", err, busy);
    end
    dega[21:11] = 11'd10;
    req = 3'b111;
    multDone = 1'b1;
    sb.push_back('{grant: 3'b100, isErr: 1'b0});
    tick();
    e = sb.pop_front();
    vectors++;
    if (grant !== e.grant || sel !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL illegal_rrptr: grant=%b sel=%0d expected %b/2", grant, sel, e.grant);
    end
    tick();
    tick();
    tick();
    req = '0;
    multDone = 1'b0;
    vectors++;
    if (done !== e.grant) begin
      miscompares++;
      $display("[TB] FAIL illegal_next_done: done=%b expected %b", done, e.grant);
    end
  endtask

  task automatic test_timeout();
    int n;
    int m;
    bit seenStart;
    bit seenErr;
    doReset();
    reqT = 3'b100;
    sb.push_back('{grant: 3'b100, isErr: 1'b1});
    seenStart = 1'b0;
    n = 0;
    while (!seenStart && n < 10) begin
      tick();
      n++;
      if (startT === 1'b1) seenStart = 1'b1;
    end
    vectors++;
    if (!seenStart || n != 2) begin
      miscompares++;
      $display("[TB] FAIL timeout_start: seen=%b after %0d cycles expected 1 after 2", seenStart, n);
    end
    seenErr = 1'b0;
    m = 0;
    while (!seenErr && m < 40) begin
      tick();
      m++;
      if (errT !== 3'b000) seenErr = 1'b1;
    end
    reqT = '0;
    e = sb.pop_front();
    vectors++;
    if (!seenErr || m != 16 || errT !== e.grant || doneT !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL timeout_err: seen=%b cycles=%0d err=%b done=%b expected 1/16/%b/000",
               seenErr, m, errT, doneT, e.grant);
    end
    tick();
    vectors++;
    if (busyT !== 1'b0 || errT !== 3'b000 || grantT !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL timeout_idle: busy=%b err=%b grant=%b expected 0/000/000", busyT, errT, grantT);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit quiet;
    doReset();
    req = 3'b010;
    tick();
    vectors++;
    if (grant !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL midrst_grant: grant=%b expected 010", grant);
    end
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if ({start, mDega, mDegb, sel, grant, done, err, busy} !== 34'd0) begin
      miscompares++;
      $display("[TB] FAIL midrst_async: got %h expected 0", {start, mDega, mDegb, sel, grant, done, err, busy});
    end
    quiet = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (done !== 3'b000 || err !== 3'b000 || grant !== 3'b000) quiet = 1'b0;
    end
    rst = 1'b0;
    req = 3'b011;
    sb.push_back('{grant: 3'b001, isErr: 1'b0});
    tick();
    if (done !== 3'b000 || err !== 3'b000) quiet = 1'b0;
    vectors++;
    if (quiet !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_no_pulse: quiet=%b expected 1", quiet);
    end
    e = sb.pop_front();
    vectors++;
    if (grant !== e.grant) begin
      miscompares++;
      $display("[TB] FAIL midrst_first_grant: grant=%b expected %b", grant, e.grant);
    end
    req = '0;
  endtask

  task automatic test_stray_done();
    bit quiet;
    doReset();
    multDone = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy !== 1'b0 || done !== 3'b000 || err !== 3'b000) quiet = 1'b0;
    end
    vectors++;
    if (quiet !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stray_idle: quiet=%b expected 1", quiet);
    end
    multDone = 1'b0;
    req = 3'b001;
    sb.push_back('{grant: 3'b001, isErr: 1'b0});
    tick();
    multDone = 1'b1;
    tick();
    multDone = 1'b0;
    vectors++;
    if (start !== 1'b1 || done !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL stray_load: start=%b done=%b expected 1/000", start, done);
    end
    tick();
    tick();
    vectors++;
    if (busy !== 1'b1 || done !== 3'b000 || grant !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL stray_wait: busy=%b done=%b grant=%b expected 1/000/001", busy, done, grant);
    end
    multDone = 1'b1;
    tick();
    multDone = 1'b0;
    req = '0;
    e = sb.pop_front();
    vectors++;
    if (done !== e.grant) begin
      miscompares++;
      $display("[TB] FAIL stray_final_done: done=%b expected %b", done, e.grant);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal_degree();
    test_timeout();
    test_reset_mid_wait();
    test_stray_done();
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
